// File: rtl/mux32_arb_if.sv
// rtl/mux32_arb_if.sv - two-requester arbiter bus bundle
interface mux32_arb_if #(parameter int WIDTH = 32);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic [7:0]       xfer_count;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_src, xfer_count
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_src, xfer_count
  );
endinterface

// File: rtl/mux32_arb.sv
// rtl/mux32_arb.sv - round-robin 2:1 arbiter with a one-word registered output slot
module mux32_arb #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mux32_arb_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state;
  logic             r_last;
  logic [WIDTH-1:0] r_data;
  logic             r_src;
  logic [7:0]       r_count;

  logic             w_slot_free;
  logic             w_gnt0;
  logic             w_gnt1;
  logic [WIDTH-1:0] w_mux_data;

  // Gating with rst_n keeps both readies low for the whole reset pulse.
  assign w_slot_free = rst_n && ((r_state == IDLE) || bus.out_ready);
  assign w_gnt0      = w_slot_free && bus.in0_valid && (!bus.in1_valid || r_last);
  assign w_gnt1      = w_slot_free && bus.in1_valid && (!bus.in0_valid || !r_last);
  assign w_mux_data  = w_gnt1 ? bus.in1_data : bus.in0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_data  <= '0;
      r_src   <= 1'b0;
      r_count <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_state <= HOLD;
            r_data  <= w_mux_data;
            r_src   <= w_gnt1;
            r_last  <= w_gnt1;
            r_count <= r_count + 8'd1;
          end
        end
        HOLD: begin
          if (w_gnt0 || w_gnt1) begin
            r_data  <= w_mux_data;
            r_src   <= w_gnt1;
            r_last  <= w_gnt1;
            r_count <= r_count + 8'd1;
          end else if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in0_ready  = w_gnt0;
  assign bus.in1_ready  = w_gnt1;
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.out_data   = r_data;
  assign bus.out_src    = r_src;
  assign bus.xfer_count = r_count;
endmodule

// File: tb/tb_mux32_arb.sv
// tb/tb_mux32_arb.sv - randomized self-checking bench for mux32_arb
module tb_mux32_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  mux32_arb_if #(.WIDTH(32)) bus();
  mux32_arb #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: the single output slot plus round-robin memory.
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_src;
  logic [7:0]  m_cnt;
  logic        m_last;

  function automatic int model_grant();
    if (m_valid && !bus.out_ready) return -1;
    if (bus.in0_valid && bus.in1_valid) return m_last ? 0 : 1;
    if (bus.in0_valid) return 0;
    if (bus.in1_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_cnt = 8'd0; m_last = 1'b1;
  endtask

  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (g >= 0) begin
      m_data  = (g == 1) ? bus.in1_data : bus.in0_data;
      m_src   = (g == 1);
      m_last  = (g == 1);
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in0_valid = 0; bus.in1_valid = 0; bus.out_ready = 0;
    bus.in0_data = '0; bus.in1_data = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in0_valid = 1; bus.in1_valid = 1; bus.out_ready = 1;
    bus.in0_data = $urandom; bus.in1_data = $urandom;
    model_reset();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_src !== 1'b0) begin n_fail++; $display("FAIL reset_out_src got %0b want 0", bus.out_src); end
    n_cmp++; if (bus.xfer_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.xfer_count); end
    n_cmp++; if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {bus.in0_ready, bus.in1_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in0_valid = 0; bus.in1_valid = 0;
  endtask

  task automatic test_single();
    do_reset();
    bus.in0_valid = 1; bus.in0_data = 32'hDEAD_BEEF; bus.out_ready = 1;
    #1;
    n_cmp++; if (bus.in0_ready !== 1'b1) begin n_fail++; $display("FAIL single_in0_ready got %0b want 1", bus.in0_ready); end
    tick();
    bus.in0_valid = 0;
    #1;
    n_cmp++; if ({bus.out_valid, bus.out_src} !== 2'b10) begin n_fail++; $display("FAIL single_valid_src got %b want 10", {bus.out_valid, bus.out_src}); end
    n_cmp++; if (bus.out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data got %h want deadbeef", bus.out_data); end
    n_cmp++; if (bus.xfer_count !== 8'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", bus.xfer_count); end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    bus.in0_valid = 1; bus.in1_valid = 1; bus.out_ready = 1;
    bus.in0_data = 32'h1; bus.in1_data = 32'h2;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      n_cmp++;
      if (bus.out_src !== i[0] || bus.out_data !== (i[0] ? 32'h2 : 32'h1) || bus.out_src !== m_src) begin
        n_fail++; $display("FAIL alternate_%0d got src %0b data %h want src %0b data %h", i, bus.out_src, bus.out_data, i[0], i[0] ? 32'h2 : 32'h1);
      end
    end
    bus.in0_valid = 0; bus.in1_valid = 0;
    n_cmp++; if (bus.xfer_count !== 8'd4) begin n_fail++; $display("FAIL alternate_count got %0d want 4", bus.xfer_count); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] d1;
    do_reset();
    bus.in0_valid = 1; bus.in0_data = 32'hA5A5_A5A5; bus.out_ready = 0;
    tick();
    d1 = $urandom;
    bus.in0_valid = 0; bus.in1_valid = 1; bus.in1_data = d1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (bus.out_data !== 32'hA5A5_A5A5 || bus.out_valid !== 1'b1 || bus.in1_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d got data %h valid %0b in1_ready %0b want a5a5a5a5 1 0", i, bus.out_data, bus.out_valid, bus.in1_ready);
      end
      tick();
    end
    bus.out_ready = 1;
    #1;
    n_cmp++; if (bus.in1_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %0b want 1", bus.in1_ready); end
    tick();
    bus.in1_valid = 0;
    #1;
    n_cmp++; if (bus.out_data !== d1 || bus.out_src !== 1'b1) begin n_fail++; $display("FAIL stall_next_word got %h/%0b want %h/1", bus.out_data, bus.out_src, d1); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.in1_valid = 1; bus.out_ready = 1;
    for (int i = 0; i < 256; i++) begin
      bus.in1_data = $urandom;
      tick();
    end
    bus.in1_valid = 0;
    #1;
    n_cmp++; if (bus.xfer_count !== 8'd0) begin n_fail++; $display("FAIL wrap_256 got %0d want 0", bus.xfer_count); end
    bus.in1_valid = 1;
    tick();
    bus.in1_valid = 0;
    #1;
    n_cmp++; if (bus.xfer_count !== 8'd1) begin n_fail++; $display("FAIL wrap_257 got %0d want 1", bus.xfer_count); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.in0_valid = 1; bus.in0_data = $urandom; bus.out_ready = 0;
    tick();
    bus.in0_valid = 0;
    #1 rst_n = 1'b0;
    model_reset();
    bus.in0_valid = 1; bus.in1_valid = 1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.xfer_count !== 8'd0) begin n_fail++; $display("FAIL async_reset got valid %0b count %0d want 0 0", bus.out_valid, bus.xfer_count); end
    n_cmp++; if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin n_fail++; $display("FAIL async_reset_ready got %b want 00", {bus.in0_ready, bus.in1_ready}); end
    #1 rst_n = 1'b1;
    #1;
    n_cmp++; if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin n_fail++; $display("FAIL async_tie got %b want 10", {bus.in0_ready, bus.in1_ready}); end
    tick();
    bus.in0_valid = 0; bus.in1_valid = 0;
    #1;
    n_cmp++; if (bus.out_src !== 1'b0 || bus.xfer_count !== 8'd1) begin n_fail++; $display("FAIL async_first_grant got src %0b count %0d want 0 1", bus.out_src, bus.xfer_count); end
    bus.out_ready = 1;
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    bus.in0_valid = 1; bus.in0_data = $urandom; bus.out_ready = 0;
    tick();
    bus.in0_valid = 0; bus.out_ready = 1;
    tick();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle got %0b want 0", bus.out_valid); end
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = i[0];
      tick();
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.xfer_count !== 8'd1 || bus.out_data !== m_data) begin
        n_fail++; $display("FAIL drain_toggle_%0d got valid %0b count %0d data %h want 0 1 %h", i, bus.out_valid, bus.xfer_count, bus.out_data, m_data);
      end
    end
  endtask

  task automatic test_random();
    logic took0, took1;
    int g;
    do_reset();
    took0 = 1; took1 = 1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in0_valid || took0) begin bus.in0_valid = $urandom_range(0, 1); bus.in0_data = $urandom; end
      if (!bus.in1_valid || took1) begin bus.in1_valid = $urandom_range(0, 1); bus.in1_data = $urandom; end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_grant();
      n_cmp++;
      if (bus.in0_ready !== (g == 0) || bus.in1_ready !== (g == 1)) begin
        n_fail++; $display("FAIL random_ready_%0d got %0b%0b want grant %0d", i, bus.in0_ready, bus.in1_ready, g);
      end
      n_cmp++;
      if (bus.out_valid !== m_valid || bus.out_src !== m_src || bus.out_data !== m_data || bus.xfer_count !== m_cnt) begin
        n_fail++; $display("FAIL random_out_%0d got %0b/%0b/%h/%0d want %0b/%0b/%h/%0d", i, bus.out_valid, bus.out_src, bus.out_data, bus.xfer_count, m_valid, m_src, m_data, m_cnt);
      end
      took0 = (g == 0); took1 = (g == 1);
      tick();
    end
  endtask

  initial begin
    bus.in0_valid = 0; bus.in1_valid = 0; bus.out_ready = 0;
    bus.in0_data = '0; bus.in1_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_wrap();
    test_async_reset();
    test_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mux32_arb.md
MUX32_ARB -- requirements
Module: mux32_arb

Interface
REQ-001 Parameter: WIDTH, 32, data width of each requester channel and the output channel.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in0_valid  input  1  requester 0 has a word to transfer.
REQ-005 Port: in0_data  input  WIDTH  requester 0 word.
REQ-006 Port: in0_ready  output  1  requester 0 word accepted this cycle (combinational).
REQ-007 Port: in1_valid  input  1  requester 1 has a word to transfer.
REQ-008 Port: in1_data  input  WIDTH  requester 1 word.
REQ-009 Port: in1_ready  output  1  requester 1 word accepted this cycle (combinational).
REQ-010 Port: out_valid  output  1  out_data holds an undelivered word (registered).
REQ-011 Port: out_data  output  WIDTH  registered output word, selected through a WIDTH-bit 2:1 mux.
REQ-012 Port: out_src  output  1  source of the word in out_data: 0 = requester 0, 1 = requester 1 (registered).
REQ-013 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-014 Port: xfer_count  output  8  count of words accepted from requesters, wraps 255 -> 0.

Function
REQ-015 Two states SHALL exist: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-016 Slot free SHALL be defined as: state IDLE, or state HOLD with out_ready=1.
REQ-017 Grant SHALL occur only when slot free and at least one inX_valid=1; at most one of in0_ready/in1_ready SHALL be 1 in any cycle.
REQ-018 Only in0_valid=1: grant requester 0; only in1_valid=1: grant requester 1.
REQ-019 Both valid: grant the requester opposite to the priority pointer's last-granted value (round-robin).
REQ-020 Priority pointer SHALL update to the granted requester on each grant and hold otherwise.
REQ-021 On grant, next edge: out_data <= granted inX_data, out_src <= granted index, state <= HOLD, xfer_count <= xfer_count+1 mod 256.
REQ-022 Latency: word accepted in cycle N SHALL appear with out_valid=1 in cycle N+1.
REQ-023 HOLD, out_ready=0: out_data, out_src, out_valid SHALL be stable; in0_ready=in1_ready=0.
REQ-024 HOLD, out_ready=1, no requester valid: state <= IDLE next edge.
REQ-025 HOLD, out_ready=1, requester valid: delivery and new grant in same cycle, state stays HOLD (one word per cycle sustained).
REQ-026 Requesters SHALL hold valid and data stable until ready; the block SHALL NOT depend on ready to drive valid (no combinational loop from inX_valid to inX_ready other than grant selection).
REQ-027 out_ready while IDLE SHALL be ignored.
REQ-028 Both requesters continuously valid with out_ready=1 SHALL yield strictly alternating out_src 0,1,0,1...

Reset
REQ-029 rst_n=0 SHALL immediately, regardless of clk: state IDLE, out_valid=0, out_data=0, out_src=0, xfer_count=0, pointer = last-granted 1 (requester 0 wins first tie).
REQ-030 Reset asserted mid-HOLD SHALL discard the held word; no ready SHALL be asserted while rst_n=0.
REQ-031 After rst_n deasserts, first grant SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-032 Reset, then in0_valid=1 in0_data=32'hDEAD_BEEF, out_ready=1 -> in0_ready=1 cycle 0; cycle 1 out_valid=1, out_data=32'hDEAD_BEEF, out_src=0, xfer_count=1.
REQ-033 Both valid from reset, data 32'h0000_0001 / 32'h0000_0002, out_ready=1 for 4 cycles -> out_src 0,1,0,1; out_data 1,2,1,2; xfer_count=4.
REQ-034 HOLD with out_data=32'hA5A5_A5A5, out_ready=0 for 5 cycles, in1_valid=1 -> out_data stable, in1_ready=0 all 5 cycles; out_ready=1 on cycle 6 -> in1_ready=1 same cycle, in1 word out next cycle.
REQ-035 256 single transfers from requester 1 -> xfer_count returns to 0; 257th -> 1.
REQ-036 rst_n pulsed low between edges during HOLD -> out_valid=0 and xfer_count=0 immediately, before next clk edge; next tie goes to requester 0.
REQ-037 Single word delivered, no further requests -> out_valid=0 the cycle after out_ready=1; subsequent out_ready toggling -> no state change.
